// File: rtl/serializer_p2s_if.sv
// Word-in / bit-out bundle for the parallel-to-serial front end.
// master drives words in and observes the serial side; slave is the serializer itself.
interface serializer_p2s_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, last, busy
  );
endinterface

// File: rtl/serializer_p2s.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out one bit per clock on x,
// back-to-back words with no gap so detector patterns may span word boundaries.
module serializer_p2s #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  serializer_p2s_if.slave  bus,
  output logic             state_dbg
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             x_r, x_n;
  logic             xv_r, xv_n;
  logic             last_r, last_n;
  logic             ready;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready is high in IDLE and on the final bit of a word, never during reset;
  // the upstream must hold din stable while din_valid is high and not yet accepted.
  always_comb begin
    ready   = 1'b0;
    accept  = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    x_n     = IDLE_BIT;
    xv_n    = 1'b0;
    last_n  = 1'b0;

    ready  = !reset && ((state == IDLE) || (cnt == '0));
    accept = bus.din_valid && ready;

    if (accept) begin
      // shreg keeps only the bits still to be sent after the one going to x
      state_n = SHIFT;
      shreg_n = advance(bus.din);
      x_n     = first_bit(bus.din);
      xv_n    = 1'b1;
      cnt_n   = CW'(WIDTH - 1);
      last_n  = (WIDTH == 1);
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            x_n     = first_bit(shreg);
            shreg_n = advance(shreg);
            xv_n    = 1'b1;
            cnt_n   = cnt - 1'b1;
            last_n  = (cnt == CW'(1));
          end else begin
            state_n = IDLE;
            shreg_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      x_r    <= IDLE_BIT;
      xv_r   <= 1'b0;
      last_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      x_r    <= x_n;
      xv_r   <= xv_n;
      last_r <= last_n;
    end
  end

  assign bus.din_ready = ready;
  assign bus.x         = x_r;
  assign bus.x_valid   = xv_r;
  assign bus.last      = last_r;
  assign bus.busy      = xv_r;
  assign state_dbg     = (state == SHIFT);
endmodule

// File: tb/tb_serializer_p2s.sv
// Directed bench for serializer_p2s: MSB-first 8-bit, LSB-first 8-bit and 1-bit instances
// sharing one clock and reset, with a small 111 run detector on the serial stream.
module tb_serializer_p2s;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  serializer_p2s_if #(.WIDTH(8)) if8 ();
  serializer_p2s_if #(.WIDTH(8)) ifl ();
  serializer_p2s_if #(.WIDTH(1)) if1 ();
  logic dbg8, dbgl, dbg1;

  serializer_p2s #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .reset(reset), .bus(if8), .state_dbg(dbg8));
  serializer_p2s #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutl (
    .clk(clk), .reset(reset), .bus(ifl), .state_dbg(dbgl));
  serializer_p2s #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .state_dbg(dbg1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if8.din_valid = 1'b1; if8.din = 8'hFF;
    ifl.din_valid = 1'b1; ifl.din = 8'hFF;
    if1.din_valid = 1'b1; if1.din = 1'b1;
    repeat (2) step();
    checks++;
    if ({if8.din_ready, if8.x, if8.x_valid, if8.last, if8.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs8: got ready,x,xv,last,busy=%b expected 00000",
               {if8.din_ready, if8.x, if8.x_valid, if8.last, if8.busy});
    end
    checks++;
    if ({if1.din_ready, if1.x_valid, ifl.din_ready, ifl.x_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs_other: got %b expected 0000",
               {if1.din_ready, if1.x_valid, ifl.din_ready, ifl.x_valid});
    end
    reset = 1'b0;
    if8.din_valid = 1'b0; ifl.din_valid = 1'b0; if1.din_valid = 1'b0;
    step();
    checks++;
    if ({if8.x_valid, if8.x, if8.din_ready} !== 3'b001) begin
      failures++;
      $display("FAIL reset_no_accept: got xv,x,ready=%b expected 001",
               {if8.x_valid, if8.x, if8.din_ready});
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    int run, hits;
    w = 8'hE0; run = 0; hits = 0;
    if8.din = w; if8.din_valid = 1'b1;
    checks++;
    if (if8.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready_idle: got %b expected 1", if8.din_ready);
    end
    step();
    if8.din_valid = 1'b0;
    if8.din = 8'($urandom_range(255, 0));
    for (int i = 0; i < 8; i++) begin
      run = if8.x ? run + 1 : 0;
      if (run == 3) hits++;
      checks++;
      if ({if8.x, if8.x_valid, if8.last, if8.busy} !== {w[7-i], 1'b1, (i == 7), 1'b1}) begin
        failures++;
        $display("FAIL single_bit%0d: got x,xv,last,busy=%b expected %b", i,
                 {if8.x, if8.x_valid, if8.last, if8.busy}, {w[7-i], 1'b1, (i == 7), 1'b1});
      end
      step();
    end
    checks++;
    if ({if8.x, if8.x_valid, if8.last, if8.busy} !== 4'b0) begin
      failures++;
      $display("FAIL single_idle_after: got %b expected 0000",
               {if8.x, if8.x_valid, if8.last, if8.busy});
    end
    checks++;
    if (hits != 1) begin
      failures++;
      $display("FAIL single_detect111: got %0d expected 1", hits);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int run, hits;
    logic exp_last;
    w = 16'h03C0; run = 0; hits = 0;
    if8.din = 8'h03; if8.din_valid = 1'b1;
    checks++;
    if (if8.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_idle: got %b expected 1", if8.din_ready);
    end
    step();
    if8.din = 8'hC0;
    for (int i = 0; i < 16; i++) begin
      exp_last = (i == 7) || (i == 15);
      run = if8.x ? run + 1 : 0;
      if (run == 3) hits++;
      checks++;
      if ({if8.x, if8.x_valid, if8.last, if8.din_ready} !== {w[15-i], 1'b1, exp_last, exp_last}) begin
        failures++;
        $display("FAIL b2b_bit%0d: got x,xv,last,ready=%b expected %b", i,
                 {if8.x, if8.x_valid, if8.last, if8.din_ready}, {w[15-i], 1'b1, exp_last, exp_last});
      end
      if (i == 8) if8.din_valid = 1'b0;
      step();
    end
    checks++;
    if ({if8.x, if8.x_valid} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_idle_after: got x,xv=%b expected 00", {if8.x, if8.x_valid});
    end
    checks++;
    if (hits != 1) begin
      failures++;
      $display("FAIL b2b_detect111: got %0d expected 1", hits);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h01;
    ifl.din = w; ifl.din_valid = 1'b1;
    step();
    ifl.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ifl.x, ifl.x_valid, ifl.last} !== {w[i], 1'b1, (i == 7)}) begin
        failures++;
        $display("FAIL lsb_bit%0d: got x,xv,last=%b expected %b", i,
                 {ifl.x, ifl.x_valid, ifl.last}, {w[i], 1'b1, (i == 7)});
      end
      step();
    end
    checks++;
    if (ifl.x_valid !== 1'b0) begin
      failures++;
      $display("FAIL lsb_idle_after: got xv=%b expected 0", ifl.x_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    if8.din = 8'hFF; if8.din_valid = 1'b1;
    step();
    if8.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({if8.x, if8.x_valid} !== 2'b11) begin
        failures++;
        $display("FAIL midrst_bit%0d: got x,xv=%b expected 11", i, {if8.x, if8.x_valid});
      end
      if (i < 2) step();
    end
    reset = 1'b1;
    if8.din_valid = 1'b1;
    step();
    checks++;
    if ({if8.x, if8.x_valid, if8.last, if8.busy, if8.din_ready} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_flush: got x,xv,last,busy,ready=%b expected 00000",
               {if8.x, if8.x_valid, if8.last, if8.busy, if8.din_ready});
    end
    reset = 1'b0;
    if8.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if8.x, if8.x_valid} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_quiet%0d: got x,xv=%b expected 00", i, {if8.x, if8.x_valid});
      end
    end
    w = 8'hA5;
    if8.din = w; if8.din_valid = 1'b1;
    step();
    if8.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({if8.x, if8.x_valid, if8.last} !== {w[7-i], 1'b1, (i == 7)}) begin
        failures++;
        $display("FAIL midrst_new_bit%0d: got x,xv,last=%b expected %b", i,
                 {if8.x, if8.x_valid, if8.last}, {w[7-i], 1'b1, (i == 7)});
      end
      step();
    end
  endtask

  task automatic test_width1();
    logic b;
    b = 1'b1;
    if1.din = b; if1.din_valid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({if1.x, if1.x_valid, if1.last, if1.din_ready} !== {b, 3'b111}) begin
        failures++;
        $display("FAIL w1_cycle%0d: got x,xv,last,ready=%b expected %b", i,
                 {if1.x, if1.x_valid, if1.last, if1.din_ready}, {b, 3'b111});
      end
      b = ~b;
      if1.din = b;
      step();
    end
    if1.din_valid = 1'b0;
    step();
    checks++;
    if ({if1.x, if1.x_valid, if1.last} !== 3'b000) begin
      failures++;
      $display("FAIL w1_idle_after: got x,xv,last=%b expected 000",
               {if1.x, if1.x_valid, if1.last});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    if8.din = '0; if8.din_valid = 1'b0;
    ifl.din = '0; ifl.din_valid = 1'b0;
    if1.din = '0; if1.din_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
